mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory-side responder for the SLC-3 CPU's MAR/MDR bus. It accepts a single-word read or write request from the control unit, runs a timed transaction on the board's asynchronous 16-bit SRAM, and returns read data to the MDR input path. It pulses `mem_resp` when the transaction completes. One address is decoded as memory-mapped I/O: reads return the switches, and writes load the hex-display register.

## Interface
- `WAIT_STATES`, default 2: extra SRAM access cycles beyond the first; legal range 0–15.
- `IO_ADDR`, default 16'hFFFF: memory-mapped I/O address.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `mem_read` in 1: read request; held by the requestor until `mem_resp`.
- `mem_write` in 1: write request; held by the requestor until `mem_resp`.
- `addr` in 16: word address (the MAR value).
- `wdata` in 16: write data (the MDR value).
- `switches` in 16: I/O read source.
- `rdata` out 16: read data (feeds MDR_In); registered.
- `mem_resp` out 1: single-cycle completion pulse; registered.
- `hex_out` out 16: hex-display register.
- `sram_addr` out 20: SRAM address, {4'b0, latched addr}.
- `sram_dq_out` out 16: SRAM write data.
- `sram_dq_oe` out 1: tristate enable for `sram_dq_out`.
- `sram_dq_in` in 16: SRAM read data.
- `sram_ce_n` out 1: SRAM chip enable, active-low.
- `sram_oe_n` out 1: SRAM output enable, active-low.
- `sram_we_n` out 1: SRAM write enable, active-low.
- `sram_ub_n` out 1: SRAM upper-byte enable, active-low.
- `sram_lb_n` out 1: SRAM lower-byte enable, active-low.

## Operation
**FSM states:** IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, RESP, WAIT_DROP.

**IDLE**
- A request is sampled here, and only here.
- The block latches `addr` and `wdata`.
- If `mem_read` and `mem_write` are both high, the read wins and the write is ignored for that transaction.
- An address equal to `IO_ADDR` bypasses the SRAM:
  - Read: `rdata`←`switches`.
  - Write: `hex_out`←`wdata`.
  - Next state is RESP.
- An SRAM read goes to READ. An SRAM write goes to WR_SETUP.

**READ**
- Signals: `ce_n`=0, `oe_n`=0, `ub_n`=0, `lb_n`=0, `we_n`=1, `dq_oe`=0.
- A wait counter is loaded with `WAIT_STATES` on entry and decrements each cycle.
- On the edge where the counter is 0: `rdata`←`sram_dq_in`, next state RESP.

**WR_SETUP**
- One cycle: `ce_n`=0, byte enables=0, `dq_oe`=1, `we_n`=1, `oe_n`=1.

**WR_PULSE**
- Same as WR_SETUP except `we_n`=0.
- Lasts `WAIT_STATES`+1 cycles, using the same counter.

**WR_HOLD**
- One cycle: `we_n`=1, with CE, byte enables and `dq_oe` still asserted, so data is held past the rising edge of WE.

**RESP**
- `mem_resp`=1 for exactly one cycle. All SRAM controls are inactive.
- If neither request is high, the next state is IDLE; otherwise WAIT_DROP.

**WAIT_DROP**
- Waits until `mem_read` and `mem_write` are both low, then goes to IDLE. This prevents a held request from being re-issued.

**General rules**
- All SRAM control outputs are registered (glitch-free). Idle values: all `*_n`=1, `dq_oe`=0.
- `sram_dq_out` and `sram_addr` are stable for the whole transaction.
- A request deasserted mid-transaction does not abort it: the access completes and `mem_resp` still pulses.
- `rdata` keeps its last value until the next read completes. Writes never change `rdata`.

## Timing
**Reset** (asynchronous, takes effect immediately):
- State IDLE, counter 0.
- `rdata`=0, `hex_out`=0, `mem_resp`=0.
- `sram_addr`=0, `sram_dq_out`=0, `dq_oe`=0, all `*_n`=1.
- A write interrupted by reset leaves the target SRAM word undefined. No further effect.

**Latencies**, with the request sampled at edge E0 and `mem_resp` high in the cycle after the edge listed:
- SRAM read: E(`WAIT_STATES`+1). With W=2, `mem_resp` is high after E3. `rdata` is valid in the same cycle and stays valid after.
- SRAM write: E(`WAIT_STATES`+3). With W=2, `mem_resp` is high after E5. The WE low pulse spans W+1 cycles.
- I/O read or write: E0, so `mem_resp` is high in the cycle after E0.

**Throughput:** minimum of one idle cycle between transactions (RESP→IDLE). Back-to-back requests are accepted at the first IDLE cycle with the requests low, then high again.

**Counter:** 4 bits. With `WAIT_STATES`=0, READ lasts one cycle and WR_PULSE lasts one cycle.

## Test plan
- **SRAM read:** model holds 16'h1234 at address 16'h0040; read 16'h0040 with W=2 → `oe_n` and `ce_n` low for 3 cycles; `mem_resp` pulses once, 3 cycles after sampling; `rdata`=16'h1234; `we_n` never low.
- **SRAM write then readback:** write 16'hBEEF to 16'h0100 → WE low for exactly 3 cycles; `dq_oe` high from WR_SETUP through WR_HOLD; `mem_resp` after E5. Then read 16'h0100 → `rdata`=16'hBEEF.
- **I/O:** `switches`=16'h00A5, read 16'hFFFF → `rdata`=16'h00A5 and `mem_resp` in the cycle after E0, with `sram_ce_n` staying 1. Write 16'h0042 to 16'hFFFF → `hex_out`=16'h0042.
- **Handshake edge cases:**
  - Request held high for 10 cycles after `mem_resp` → exactly one `mem_resp` pulse and one SRAM access.
  - `mem_read`=`mem_write`=1 → read performed; SRAM contents unchanged.
- **Reset mid-write:** assert `reset` during WR_PULSE → `we_n`, `ce_n`=1 and `dq_oe`=0 immediately (before the next edge); no `mem_resp`. After release, a new read completes normally.
- **WAIT_STATES=0 build:** read completes with `mem_resp` after E1; write completes with `mem_resp` after E3.

Source files
------------

// File: rtl/mem_ctrl.sv
// SRAM/memory-mapped-I/O responder for the SLC-3 MAR/MDR bus.
// Runs timed read/write cycles on an async 16-bit SRAM and pulses mem_resp on completion.
module mem_ctrl #(
    parameter int unsigned  WAIT_STATES = 2,
    parameter logic [15:0]  IO_ADDR     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic [15:0] switches,
    output logic [15:0] rdata,
    output logic        mem_resp,
    output logic [15:0] hex_out,
    output logic [19:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam int unsigned         CNT_W   = 4;
    localparam int unsigned         DATA_W  = 16;
    localparam logic [CNT_W-1:0]    WAIT_LD = CNT_W'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_RESP,
        S_WAIT_DROP
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic [DATA_W-1:0]  r_hex;
    logic               r_resp;
    logic               r_ce_n;
    logic               r_oe_n;
    logic               r_we_n;
    logic               r_be_n;
    logic               r_dq_oe;

    logic w_req;
    logic w_cnt_zero;

    assign w_req      = mem_read | mem_write;
    assign w_cnt_zero = (r_cnt == '0);

    // Transaction sequencer; every SRAM strobe is a flop so the pins never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_hex   <= '0;
            r_resp  <= 1'b0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_be_n  <= 1'b1;
            r_dq_oe <= 1'b0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        if (addr == IO_ADDR) begin
                            if (mem_read) begin
                                r_rdata <= switches;
                            end else begin
                                r_hex <= wdata;
                            end
                            r_resp  <= 1'b1;
                            r_state <= S_RESP;
                        end else if (mem_read) begin
                            r_cnt   <= WAIT_LD;
                            r_ce_n  <= 1'b0;
                            r_oe_n  <= 1'b0;
                            r_be_n  <= 1'b0;
                            r_state <= S_READ;
                        end else begin
                            r_ce_n  <= 1'b0;
                            r_be_n  <= 1'b0;
                            r_dq_oe <= 1'b1;
                            r_state <= S_WR_SETUP;
                        end
                    end
                end
                S_READ: begin
                    if (w_cnt_zero) begin
                        r_rdata <= sram_dq_in;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_be_n  <= 1'b1;
                        r_resp  <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_WR_SETUP: begin
                    r_we_n  <= 1'b0;
                    r_cnt   <= WAIT_LD;
                    r_state <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (w_cnt_zero) begin
                        r_we_n  <= 1'b1;
                        r_state <= S_WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_WR_HOLD: begin
                    // Data and CE stay driven one cycle past the WE rising edge.
                    r_ce_n  <= 1'b1;
                    r_be_n  <= 1'b1;
                    r_dq_oe <= 1'b0;
                    r_resp  <= 1'b1;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= w_req ? S_WAIT_DROP : S_IDLE;
                end
                S_WAIT_DROP: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata       = r_rdata;
    assign mem_resp    = r_resp;
    assign hex_out     = r_hex;
    assign sram_addr   = {4'h0, r_addr};
    assign sram_dq_out = r_wdata;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_ce_n   = r_ce_n;
    assign sram_oe_n   = r_oe_n;
    assign sram_we_n   = r_we_n;
    assign sram_ub_n   = r_be_n;
    assign sram_lb_n   = r_be_n;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed vector table on a W=2 instance with an SRAM model,
// plus handshake/reset sequences and a W=0 instance for minimum latency.
module tb_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        mem_read, mem_write;
    logic [15:0] addr, wdata, switches;
    logic [15:0] rdata, hex_out, sram_dq_out, sram_dq_in;
    logic        mem_resp, sram_dq_oe;
    logic [19:0] sram_addr;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    logic        z_read, z_write;
    logic [15:0] z_addr, z_wdata;
    logic [15:0] z_rdata, z_hex, z_dq_out, z_dq_in;
    logic        z_resp, z_dq_oe;
    logic [19:0] z_sram_addr;
    logic        z_ce_n, z_oe_n, z_we_n, z_ub_n, z_lb_n;

    int n_chk  = 0;
    int n_fail = 0;
    int resp_cnt = 0;
    int acc_cnt  = 0;

    logic [15:0] mem [0:65535];

    mem_ctrl #(.WAIT_STATES(2), .IO_ADDR(16'hFFFF)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .switches(switches), .rdata(rdata),
        .mem_resp(mem_resp), .hex_out(hex_out), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    mem_ctrl #(.WAIT_STATES(0), .IO_ADDR(16'hFFFF)) dut0 (
        .clk(clk), .reset(reset), .mem_read(z_read), .mem_write(z_write),
        .addr(z_addr), .wdata(z_wdata), .switches(16'h0000), .rdata(z_rdata),
        .mem_resp(z_resp), .hex_out(z_hex), .sram_addr(z_sram_addr),
        .sram_dq_out(z_dq_out), .sram_dq_oe(z_dq_oe), .sram_dq_in(z_dq_in),
        .sram_ce_n(z_ce_n), .sram_oe_n(z_oe_n), .sram_we_n(z_we_n),
        .sram_ub_n(z_ub_n), .sram_lb_n(z_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Async SRAM model: reads while CE/OE low, latches on the WE rising edge.
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[15:0]] : 16'h0000;
    assign z_dq_in    = (!z_ce_n && !z_oe_n) ? 16'h5A5A : 16'h0000;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0040] = 16'h1234;
        forever begin
            @(posedge sram_we_n);
            if (!sram_ce_n && sram_dq_oe) mem[sram_addr[15:0]] = sram_dq_out;
        end
    end

    always @(posedge clk) if (mem_resp) resp_cnt++;
    always @(negedge sram_ce_n) acc_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue a request, hold it until mem_resp, and tally strobe activity per cycle.
    task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, output int lat, output int n_ce,
                          output int n_oe, output int n_we, output int n_dq,
                          output logic ok);
        lat = -1; n_ce = 0; n_oe = 0; n_we = 0; n_dq = 0; ok = 1'b1;
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (!sram_ce_n) n_ce++;
            if (!sram_oe_n) n_oe++;
            if (!sram_we_n) n_we++;
            if (sram_dq_oe) n_dq++;
            if (!sram_ce_n && sram_addr != {4'h0, a}) ok = 1'b0;
            if (sram_ub_n != sram_ce_n || sram_lb_n != sram_ce_n) ok = 1'b0;
            if (sram_dq_oe && sram_dq_out != d) ok = 1'b0;
            if (mem_resp) lat = k;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        if (mem_resp) ok = 1'b0;
    endtask

    task automatic zdo(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] d, output int lat, output int n_we,
                       output int n_dq);
        lat = -1; n_we = 0; n_dq = 0;
        z_read = rd; z_write = wr; z_addr = a; z_wdata = d;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (!z_we_n) n_we++;
            if (z_dq_oe && z_dq_out == d) n_dq++;
            if (z_resp) lat = k;
        end
        z_read = 1'b0; z_write = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] sw;
        logic [15:0] exp_rd;
        logic [15:0] exp_hex;
        int          lat;
        int          ce;
        int          oe;
        int          we;
        int          dq;
    } vec_t;

    vec_t vt [12];

    initial begin
        int   lat, n_ce, n_oe, n_we, n_dq, r0, a0;
        logic ok;

        vt[0]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 3, 3, 3, 0, 0};
        vt[1]  = '{1'b0, 1'b1, 16'h0100, 16'hBEEF, 16'h0000, 16'h1234, 16'h0000, 5, 5, 0, 3, 5};
        vt[2]  = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 3, 3, 3, 0, 0};
        vt[3]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 16'h00A5, 16'h0000, 0, 0, 0, 0, 0};
        vt[4]  = '{1'b0, 1'b1, 16'hFFFF, 16'h0042, 16'h00A5, 16'h00A5, 16'h0042, 0, 0, 0, 0, 0};
        vt[5]  = '{1'b0, 1'b1, 16'h0200, 16'h7777, 16'h0000, 16'h00A5, 16'h0042, 5, 5, 0, 3, 5};
        vt[6]  = '{1'b1, 1'b0, 16'h0200, 16'h0000, 16'h0000, 16'h7777, 16'h0042, 3, 3, 3, 0, 0};
        vt[7]  = '{1'b1, 1'b1, 16'h0040, 16'hDEAD, 16'h0000, 16'h1234, 16'h0042, 3, 3, 3, 0, 0};
        vt[8]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000, 16'h1234, 16'h0042, 3, 3, 3, 0, 0};
        vt[9]  = '{1'b0, 1'b1, 16'hFFFE, 16'h1111, 16'h0000, 16'h1234, 16'h0042, 5, 5, 0, 3, 5};
        vt[10] = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h0000, 16'h1111, 16'h0042, 3, 3, 3, 0, 0};
        vt[11] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h5A3C, 16'h5A3C, 16'h0042, 0, 0, 0, 0, 0};

        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        addr = '0; wdata = '0; switches = '0;
        z_read = 1'b0; z_write = 1'b0; z_addr = '0; z_wdata = '0;
        #12;
        chk("rst rdata", 32'(rdata), 32'h0);
        chk("rst hex", 32'(hex_out), 32'h0);
        chk("rst resp", 32'(mem_resp), 32'h0);
        chk("rst sram_addr", 32'(sram_addr), 32'h0);
        chk("rst dq_out", 32'(sram_dq_out), 32'h0);
        chk("rst dq_oe", 32'(sram_dq_oe), 32'h0);
        chk("rst ctl_n", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            switches = vt[i].sw;
            do_req(vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, lat, n_ce, n_oe, n_we, n_dq, ok);
            chk($sformatf("v%0d lat", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d rdata", i), 32'(rdata), 32'(vt[i].exp_rd));
            chk($sformatf("v%0d hex", i), 32'(hex_out), 32'(vt[i].exp_hex));
            chk($sformatf("v%0d ce_cycles", i), 32'(n_ce), 32'(vt[i].ce));
            chk($sformatf("v%0d oe_cycles", i), 32'(n_oe), 32'(vt[i].oe));
            chk($sformatf("v%0d we_cycles", i), 32'(n_we), 32'(vt[i].we));
            chk($sformatf("v%0d dq_oe_cycles", i), 32'(n_dq), 32'(vt[i].dq));
            chk($sformatf("v%0d bus_stable", i), 32'(ok), 32'h1);
        end

        // Request held well past mem_resp: exactly one pulse and one access.
        r0 = resp_cnt; a0 = acc_cnt;
        mem_read = 1'b1; addr = 16'h0040;
        repeat (16) @(posedge clk);
        #1;
        mem_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("held resp_pulses", 32'(resp_cnt - r0), 32'h1);
        chk("held sram_accesses", 32'(acc_cnt - a0), 32'h1);
        chk("held rdata", 32'(rdata), 32'h1234);

        // Request dropped right after acceptance still completes.
        mem_write = 1'b1; addr = 16'h0300; wdata = 16'hABCD;
        @(posedge clk); #1;
        mem_write = 1'b0;
        lat = -1;
        for (int k = 1; k < 40 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (mem_resp) lat = k;
        end
        chk("drop lat", 32'(lat), 32'h5);
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 16'h0300, 16'h0000, lat, n_ce, n_oe, n_we, n_dq, ok);
        chk("drop readback", 32'(rdata), 32'hABCD);

        // Reset asserted in the middle of the WE pulse.
        r0 = resp_cnt;
        mem_write = 1'b1; addr = 16'h0400; wdata = 16'h1357;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstmid we_low", 32'(sram_we_n), 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("rstmid ctl_n", 32'({sram_ce_n, sram_we_n, sram_oe_n}), 32'h7);
        chk("rstmid dq_oe", 32'(sram_dq_oe), 32'h0);
        chk("rstmid resp", 32'(mem_resp), 32'h0);
        mem_write = 1'b0;
        @(posedge clk); #1;
        chk("rstmid rdata", 32'(rdata), 32'h0);
        chk("rstmid hex", 32'(hex_out), 32'h0);
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid no_resp", 32'(resp_cnt - r0), 32'h0);
        do_req(1'b1, 1'b0, 16'h0040, 16'h0000, lat, n_ce, n_oe, n_we, n_dq, ok);
        chk("rstmid read lat", 32'(lat), 32'h3);
        chk("rstmid read rdata", 32'(rdata), 32'h1234);

        // Zero wait-state instance.
        zdo(1'b1, 1'b0, 16'h0123, 16'h0000, lat, n_we, n_dq);
        chk("w0 read lat", 32'(lat), 32'h1);
        chk("w0 read rdata", 32'(z_rdata), 32'h5A5A);
        chk("w0 read addr", 32'(z_sram_addr), 32'h00123);
        zdo(1'b0, 1'b1, 16'h0456, 16'hC0DE, lat, n_we, n_dq);
        chk("w0 write lat", 32'(lat), 32'h3);
        chk("w0 write we_cycles", 32'(n_we), 32'h1);
        chk("w0 write dq_cycles", 32'(n_dq), 32'h3);
        chk("w0 write rdata_kept", 32'(z_rdata), 32'h5A5A);
        chk("w0 idle ctl", 32'({z_ub_n, z_lb_n, z_ce_n}), 32'h7);
        chk("w0 hex", 32'(z_hex), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
